bp_be_cmd_pair_stager: RTL and testbench

BP_BE_CMD_PAIR_STAGER -- requirements
Module: bp_be_cmd_pair_stager

---
 rtl/bp_be_pkg.sv | 50 +++++
 rtl/bp_be_cmd_squash_filter.sv | 30 +++
 rtl/bp_be_cmd_pair_stager.sv | 102 ++++++++++
 tb/tb_bp_be_cmd_pair_stager.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Backend shared types: processor configs, fe_cmd opcodes and layout, and the
// state encoding of the commit-to-cmd-queue pair stager.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_sv48_cfg    = 2'd1
  } bp_params_e;

  typedef enum logic [2:0] {
    e_op_state_reset          = 3'd0,
    e_op_pc_redirection       = 3'd1,
    e_op_icache_fill_response = 3'd2,
    e_op_icache_fence         = 3'd3,
    e_op_attaches             = 3'd4,
    e_op_itlb_fill_response   = 3'd5,
    e_op_itlb_fence           = 3'd6,
    e_op_wait                 = 3'd7
  } bp_fe_command_queue_opcodes_e;

  localparam int fe_cmd_opcode_width_gp   = 3;
  localparam int fe_cmd_operands_width_gp = 32;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    return (cfg == e_bp_sv48_cfg) ? 48 : 39;
  endfunction

  function automatic int bp_fe_cmd_width(bp_params_e cfg);
    return fe_cmd_operands_width_gp + bp_vaddr_width(cfg) + fe_cmd_opcode_width_gp;
  endfunction

  // Default-config layout; the opcode always occupies the low bits in every config
  typedef struct packed {
    logic [fe_cmd_operands_width_gp-1:0] operands;
    logic [38:0]                         pc;
    bp_fe_command_queue_opcodes_e        opcode;
  } bp_fe_cmd_s;

  // A redirect or itlb fill makes anything younger in the same commit stale
  function automatic logic bp_fe_cmd_squashes_younger(bp_fe_command_queue_opcodes_e op);
    return (op == e_op_pc_redirection) || (op == e_op_itlb_fill_response);
  endfunction

  typedef enum logic [1:0] {
    e_stg_empty = 2'd0,
    e_stg_one   = 2'd1,
    e_stg_two   = 2'd2
  } bp_be_cmd_stager_state_e;

endpackage

// File: rtl/bp_be_cmd_squash_filter.sv
// Combinational front of the stager: how many of the committed pair survive,
// which one becomes head, and whether the younger one is dropped.
module bp_be_cmd_squash_filter
  import bp_be_pkg::*;
#(parameter int fe_cmd_width_p = 74)
 (input  logic [fe_cmd_width_p-1:0] cmd0_i
  , input  logic [fe_cmd_width_p-1:0] cmd1_i
  , input  logic                      cmd0_v_i
  , input  logic                      cmd1_v_i
  , output logic [1:0]                cnt_o
  , output logic [fe_cmd_width_p-1:0] head_o
  , output logic [fe_cmd_width_p-1:0] tail_o
  , output logic                      drop_o
  );

  bp_fe_command_queue_opcodes_e op0;
  assign op0    = bp_fe_command_queue_opcodes_e'(cmd0_i[fe_cmd_opcode_width_gp-1:0]);
  assign drop_o = cmd0_v_i & cmd1_v_i & bp_fe_cmd_squashes_younger(op0);

  always_comb begin
    cnt_o  = 2'd0;
    head_o = cmd0_v_i ? cmd0_i : cmd1_i;
    tail_o = cmd1_i;
    if (cmd0_v_i & cmd1_v_i & ~drop_o)
      cnt_o = 2'd2;
    else if (cmd0_v_i | cmd1_v_i)
      cnt_o = 2'd1;
  end

endmodule

// File: rtl/bp_be_cmd_pair_stager.sv
// Stages up to two committed fe_cmd packets per cycle into the two cmd-queue
// enqueue ports, oldest first. Optional perf counters: BP_BE_CMD_STAGER_PERF_EN.
module bp_be_cmd_pair_stager
  import bp_be_pkg::*;
#(parameter bp_params_e bp_params_p = e_bp_default_cfg
  , localparam int fe_cmd_width_lp = bp_fe_cmd_width(bp_params_p))
 (input  logic                       clk_i
  , input  logic                       reset_i
  , input  logic [fe_cmd_width_lp-1:0] cmd0_i
  , input  logic [fe_cmd_width_lp-1:0] cmd1_i
  , input  logic                       cmd0_v_i
  , input  logic                       cmd1_v_i
  , output logic                       ready_o
  , output logic [fe_cmd_width_lp-1:0] fe_cmd_o
  , output logic [fe_cmd_width_lp-1:0] fe_cmd_o2
  , output logic                       fe_cmd_v_o
  , output logic                       fe_cmd_v_o2
  , input  logic                       fe_cmd_ready_i
  , input  logic                       fe_cmd_ready_i2
  , output logic                       squash_o
`ifdef BP_BE_CMD_STAGER_PERF_EN
  , output logic [15:0]                squash_cnt_o
  , output logic [15:0]                stall_cnt_o
`endif
  );

  bp_be_cmd_stager_state_e state_r, state_n;
  logic [fe_cmd_width_lp-1:0] head_r, tail_r, in_head, in_tail;
  logic [1:0] in_cnt;
  logic in_drop, rdy, load, shift;

  bp_be_cmd_squash_filter #(.fe_cmd_width_p(fe_cmd_width_lp)) filter
   (.cmd0_i  (cmd0_i)
    ,.cmd1_i  (cmd1_i)
    ,.cmd0_v_i(cmd0_v_i)
    ,.cmd1_v_i(cmd1_v_i)
    ,.cnt_o   (in_cnt)
    ,.head_o  (in_head)
    ,.tail_o  (in_tail)
    ,.drop_o  (in_drop)
    );

  // Port 2 is only ever taken together with port 1; a lone port-2 ready is ignored
  always_comb begin
    state_n = state_r;
    rdy     = 1'b0;
    shift   = 1'b0;
    unique case (state_r)
      e_stg_empty: rdy = 1'b1;
      e_stg_one:   rdy = fe_cmd_ready_i;
      e_stg_two: begin
        rdy = fe_cmd_ready_i & fe_cmd_ready_i2;
        if (fe_cmd_ready_i & ~fe_cmd_ready_i2) begin
          state_n = e_stg_one;
          shift   = 1'b1;
        end
      end
      default: state_n = e_stg_empty;
    endcase
    if (rdy) begin
      unique case (in_cnt)
        2'd2:    state_n = e_stg_two;
        2'd1:    state_n = e_stg_one;
        default: state_n = e_stg_empty;
      endcase
    end
  end

  assign ready_o     = rdy & reset_i;
  assign load        = ready_o & (cmd0_v_i | cmd1_v_i);
  assign squash_o    = ready_o & in_drop;
  assign fe_cmd_o    = head_r;
  assign fe_cmd_o2   = tail_r;
  assign fe_cmd_v_o  = (state_r != e_stg_empty);
  assign fe_cmd_v_o2 = (state_r == e_stg_two);

  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) state_r <= e_stg_empty;
    else          state_r <= state_n;

  always_ff @(posedge clk_i)
    if (load) begin
      head_r <= in_head;
      tail_r <= in_tail;
    end else if (shift) begin
      head_r <= tail_r;
    end

`ifdef BP_BE_CMD_STAGER_PERF_EN
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      squash_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (squash_o && squash_cnt_o != 16'hFFFF)
        squash_cnt_o <= squash_cnt_o + 16'd1;
      if ((cmd0_v_i | cmd1_v_i) && !ready_o && stall_cnt_o != 16'hFFFF)
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bp_be_cmd_pair_stager.sv
// Randomized scoreboard bench for bp_be_cmd_pair_stager: the driver pushes each
// accepted packet into an expected queue, the monitor pops it when it is emitted.
module tb_bp_be_cmd_pair_stager;
  import bp_be_pkg::*;

  localparam int W = bp_fe_cmd_width(e_bp_default_cfg);

  logic clk_i = 1'b0, reset_i = 1'b1;
  logic [W-1:0] cmd0_i = '0, cmd1_i = '0;
  logic cmd0_v_i = 1'b0, cmd1_v_i = 1'b0;
  logic fe_cmd_ready_i = 1'b0, fe_cmd_ready_i2 = 1'b0;
  logic ready_o, fe_cmd_v_o, fe_cmd_v_o2, squash_o;
  logic [W-1:0] fe_cmd_o, fe_cmd_o2;
`ifdef BP_BE_CMD_STAGER_PERF_EN
  logic [15:0] squash_cnt_o, stall_cnt_o;
  logic [15:0] m_sq = '0, m_st = '0;
`endif

  bp_be_cmd_pair_stager #(.bp_params_p(e_bp_default_cfg)) dut
   (.clk_i(clk_i), .reset_i(reset_i)
    ,.cmd0_i(cmd0_i), .cmd1_i(cmd1_i), .cmd0_v_i(cmd0_v_i), .cmd1_v_i(cmd1_v_i)
    ,.ready_o(ready_o)
    ,.fe_cmd_o(fe_cmd_o), .fe_cmd_o2(fe_cmd_o2)
    ,.fe_cmd_v_o(fe_cmd_v_o), .fe_cmd_v_o2(fe_cmd_v_o2)
    ,.fe_cmd_ready_i(fe_cmd_ready_i), .fe_cmd_ready_i2(fe_cmd_ready_i2)
    ,.squash_o(squash_o)
`ifdef BP_BE_CMD_STAGER_PERF_EN
    ,.squash_cnt_o(squash_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0, n_out = 0;
  logic [W-1:0] exp_q[$];
  bit mdl_ready = 1'b0;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  function automatic bit kills_younger(logic [2:0] op);
    return (op == e_op_pc_redirection) || (op == e_op_itlb_fill_response);
  endfunction

  function automatic logic [W-1:0] mk(logic [2:0] op);
    bp_fe_cmd_s c;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    c.operands = $urandom();
    c.pc       = r[38:0];
    c.opcode   = bp_fe_command_queue_opcodes_e'(op);
    return c;
  endfunction

  // Monitor: outputs must show the two oldest outstanding packets; whatever the
  // queue side takes this cycle is retired, and only an empty stager may accept.
  always @(negedge clk_i) begin
    int n;
    bit sq;
    logic [W-1:0] tmp;
    n = exp_q.size();
    chk("v1", W'(fe_cmd_v_o), W'(n >= 1));
    chk("v2", W'(fe_cmd_v_o2), W'(n >= 2));
    if (n >= 1) chk("pkt1", fe_cmd_o, exp_q[0]);
    if (n >= 2) chk("pkt2", fe_cmd_o2, exp_q[1]);
    if (n >= 1 && fe_cmd_ready_i) begin
      tmp = exp_q.pop_front();
      n_out++;
      if (n >= 2 && fe_cmd_ready_i2) begin
        tmp = exp_q.pop_front();
        n_out++;
      end
    end
    mdl_ready = reset_i && (exp_q.size() == 0);
    chk("ready", W'(ready_o), W'(mdl_ready));
    sq = mdl_ready && cmd0_v_i && cmd1_v_i && kills_younger(cmd0_i[2:0]);
    chk("squash", W'(squash_o), W'(sq));
`ifdef BP_BE_CMD_STAGER_PERF_EN
    if (!reset_i) begin
      m_sq = '0;
      m_st = '0;
    end
    chk("squash_cnt", W'(squash_cnt_o), W'(m_sq));
    chk("stall_cnt", W'(stall_cnt_o), W'(m_st));
    if (reset_i) begin
      if (sq && m_sq != 16'hFFFF) m_sq++;
      if ((cmd0_v_i || cmd1_v_i) && !mdl_ready && m_st != 16'hFFFF) m_st++;
    end
`endif
  end

  // Acceptance at the edge: record what the commit stage hands over, oldest first
  task automatic take_edge();
    @(posedge clk_i);
    if (mdl_ready) begin
      if (cmd0_v_i && cmd1_v_i) begin
        exp_q.push_back(cmd0_i);
        if (!kills_younger(cmd0_i[2:0])) exp_q.push_back(cmd1_i);
      end else if (cmd0_v_i) exp_q.push_back(cmd0_i);
      else if (cmd1_v_i)     exp_q.push_back(cmd1_i);
    end
  endtask

  task automatic step(bit v0, bit v1, logic [2:0] op0, logic [2:0] op1, bit r1, bit r2);
    take_edge();
    #1;
    cmd0_v_i = v0; cmd1_v_i = v1;
    cmd0_i = mk(op0); cmd1_i = mk(op1);
    fe_cmd_ready_i = r1; fe_cmd_ready_i2 = r2;
  endtask

  task automatic do_reset(int cycles);
    take_edge();
    #1;
    reset_i = 1'b0;
    exp_q.delete();
    repeat (cycles) @(posedge clk_i);
    #1 reset_i = 1'b1;
  endtask

  initial begin
    #1 reset_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b1;

    // single command, then idle
    step(1, 0, e_op_attaches, e_op_wait, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1, 1);
    // redirect squashes the younger slot
    step(1, 1, e_op_pc_redirection, e_op_attaches, 1, 1);
    step(1, 1, e_op_itlb_fill_response, e_op_icache_fence, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1, 1);
    // lone younger slot becomes head
    step(0, 1, 0, e_op_icache_fence, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1, 1);
    // port 2 never ready: tail drains through port 1
    step(1, 1, e_op_attaches, e_op_icache_fence, 1, 0);
    repeat (4) step(1, 1, e_op_wait, e_op_attaches, 1, 0);
    // port 2 ready alone must not release anything
    step(1, 1, e_op_attaches, e_op_wait, 0, 1);
    repeat (3) step(1, 1, e_op_wait, e_op_attaches, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1, 1);
    // TWO held with both readys low and inputs valid for 5 cycles
    step(1, 1, e_op_attaches, e_op_wait, 0, 0);
    repeat (5) step(1, 1, e_op_icache_fence, e_op_wait, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, 1);
    // back-to-back pairs, both ports always ready
    for (int i = 0; i < 100; i++)
      step(1, 1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1, 1);
    // fully random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    // reset while holding a pair; nothing stale may appear afterwards
    step(1, 1, e_op_attaches, e_op_wait, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    do_reset(2);
    repeat (5) step(0, 0, 0, 0, 1, 1);

    @(negedge clk_i);
    #1;
    chk("drained", W'(exp_q.size()), W'(0));
    chk("traffic_seen", W'(n_out >= 300), W'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
